timer_responder: RTL and testbench

- Memory-mapped countdown timer that responds to the CPU's data-memory port, the same addr/wdata/we/re transaction the single-cycle core issues to dm.
- Top-level decode routes word addresses in the timer window here; the core is the initiator and this block is the responder.
- Provides three word registers, CTRL, PRESET and COUNT, plus a level interrupt line.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_responder.sv | 95 +++++++++
 tb/tb_timer_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the memory-mapped countdown timer: FSM states, register offsets, CTRL fields.
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_responder.sv
// Countdown timer responder on the core's data-memory port (CTRL/PRESET/COUNT + level irq).
// Latency: writes land at the sampling edge, reads are combinational in the same cycle.
// Backpressure: none, the responder accepts every access in the cycle it is presented.
module timer_responder
  import timer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [1:0]        state;
  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              ctrl_wr;
  logic              preset_wr;
  logic              en;
  logic              reload;
  logic              wdata_unused;

  assign ctrl_wr      = we && (addr == OFF_CTRL);
  assign preset_wr    = we && (addr == OFF_PRESET);
  assign en           = ctrl[CTRL_EN];
  assign reload       = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign wdata_unused = ^wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (preset_wr) preset <= wdata[CNT_W-1:0];
      if (ctrl_wr)   ctrl   <= wdata[CTRL_W-1:0];

      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count == '0) begin
            state <= ST_INT;
            // One-shot self-disables, but a CPU write on the same edge takes priority.
            if (!reload && !ctrl_wr) ctrl[CTRL_EN] <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_INT: begin
          if (reload) begin
            state <= en ? ST_LOAD : ST_IDLE;
          end else if (ctrl_wr) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq = (state == ST_INT) && ctrl[CTRL_IM];

  always_comb begin
    rdata = '0;
    if (re) begin
      case (addr)
        OFF_CTRL:   rdata[CTRL_W-1:0] = ctrl;
        OFF_PRESET: rdata[CNT_W-1:0]  = preset;
        OFF_COUNT:  rdata[CNT_W-1:0]  = count;
        default:    rdata             = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder: reset, one-shot, auto-reload, masking, collisions, async reset.
module tb_timer_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        irq;

  int total;
  int bad;
  int pulses;

  timer_responder #(.DATA_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    re   = 1'b1;
    #1;
    chk(tag, rdata, exp);
    re = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Write is sampled at the next rising edge; returns just after that edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;

    // Reset held with a write attempted every cycle
    reset = 1'b0;
    we    = 1'b1;
    re    = 1'b0;
    addr  = 2'd0;
    wdata = 32'hF;
    repeat (3) tick();
    chk_rd("rst_ctrl", 2'd0, 32'h0);
    chk_rd("rst_preset", 2'd1, 32'h0);
    chk_rd("rst_count", 2'd2, 32'h0);
    chk_rd("rst_off3", 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);
    we = 1'b0;
    addr = 2'd0;
    re = 1'b0;
    #1;
    chk("rst_rdata_re0", rdata, 32'h0);
    #1 reset = 1'b1;
    tick();
    chk_rd("rel_count", 2'd2, 32'h0);
    chk_rd("rel_ctrl", 2'd0, 32'h0);
    chk_irq("rel_irq", 1'b0);

    // One-shot, PRESET=3, CTRL written at edge 0
    wr(2'd1, 32'd3);
    chk_rd("os_preset", 2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick();
    chk_rd("os_cnt3", 2'd2, 32'd3);
    tick();
    chk_rd("os_cnt2", 2'd2, 32'd2);
    tick();
    chk_rd("os_cnt1", 2'd2, 32'd1);
    tick();
    chk_rd("os_cnt0", 2'd2, 32'd0);
    chk_irq("os_irq_pre", 1'b0);
    tick();
    chk_irq("os_irq", 1'b1);
    chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_irq("os_irq_hold", 1'b1);
    end
    wr(2'd0, 32'h0);
    chk_irq("os_irq_clr", 1'b0);
    chk_rd("os_count_after", 2'd2, 32'd0);

    // Auto-reload, PRESET=2: INT at edges 5,10,15,20
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 21; e++) begin
      tick();
      chk_irq("ar_irq", (e >= 5) && (e % 5 == 0));
      if (irq) pulses++;
      if (e == 7 || e == 12 || e == 17) chk_rd("ar_reload", 2'd2, 32'd2);
    end
    chk("ar_pulses", pulses, 32'd4);
    wr(2'd0, 32'h0);
    repeat (2) tick();

    // Auto-reload with IM=0, then stop while COUNT reads 2
    wr(2'd0, 32'h3);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_irq("mask_irq", 1'b0);
      if (e == 7) chk_rd("mask_reload", 2'd2, 32'd2);
    end
    chk_rd("mask_cnt2", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    chk_rd("stop_cnt1", 2'd2, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_rd("stop_hold", 2'd2, 32'd1);
    end
    chk_irq("stop_irq", 1'b0);

    // CPU write to CTRL on the exact edge of one-shot INT entry
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    wr(2'd0, 32'h9);
    chk_rd("col_ctrl", 2'd0, 32'h9);
    chk_irq("col_irq", 1'b1);
    wr(2'd2, 32'hDEAD);
    wr(2'd3, 32'hDEAD);
    chk_rd("ro_count", 2'd2, 32'd0);
    chk_rd("ro_off3", 2'd3, 32'h0);
    chk_rd("ro_ctrl", 2'd0, 32'h9);
    chk_irq("ro_irq", 1'b1);
    wr(2'd0, 32'h0);
    chk_irq("col_irq_clr", 1'b0);

    // Async reset between edges while COUNT=5
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    repeat (5) tick();
    chk_rd("ar5_count", 2'd2, 32'd5);
    #1 reset = 1'b0;
    #1;
    chk_rd("arst_count", 2'd2, 32'd0);
    chk_rd("arst_ctrl", 2'd0, 32'd0);
    chk_irq("arst_irq", 1'b0);
    #1 reset = 1'b1;

    // PRESET=0 reaches INT at edge 3; async reset must drop irq without a clock
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    chk_irq("p0_irq_pre", 1'b0);
    tick();
    chk_irq("p0_irq", 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_irq("arst_int_irq", 1'b0);
    #1 reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
